// File: rtl/sync_fifo.sv
// sync_fifo: single-clock FIFO with registered read data, flags and occupancy (i_clock, active-low sync i_reset, i_write/i_wdata push, i_read pop, o_rdata/o_empty/o_full/o_queued)
module sync_fifo #(
  parameter int DEPTH = 32,
  parameter int WIDTH = 32
) (
  input  logic             i_clock,
  input  logic             i_reset,
  input  logic             i_write,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic             i_read,
  output logic [WIDTH-1:0] o_rdata,
  output logic             o_empty,
  output logic             o_full,
  output logic [15:0]      o_queued
);
  localparam int AW = $clog2(DEPTH);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic push, pop;
  logic [15:0] count_n;
  always_comb begin
    push = i_write && !o_full;
    pop = i_read && !o_empty;
    count_n = o_queued + 16'(push) - 16'(pop);
  end
  always_ff @(posedge i_clock) begin
    if (!i_reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      o_rdata <= '0;
      o_empty <= 1'b1;
      o_full <= 1'b0;
      o_queued <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr == AW'(DEPTH - 1) ? '0 : wr_ptr + AW'(1);
      if (pop) begin
        o_rdata <= mem[rd_ptr];
        rd_ptr <= rd_ptr == AW'(DEPTH - 1) ? '0 : rd_ptr + AW'(1);
      end
      o_queued <= count_n;
      o_empty <= count_n == 16'd0;
      o_full <= count_n == 16'(DEPTH);
    end
  end
  always_ff @(posedge i_clock)
    if (i_reset && push) mem[wr_ptr] <= i_wdata;
endmodule

// File: tb/tb_sync_fifo.sv
// tb_sync_fifo: directed vector table plus modelled sequences for sync_fifo (DEPTH=32, WIDTH=32)
module tb_sync_fifo;
  logic i_clock = 0, i_reset = 1, i_write = 0, i_read = 0;
  logic [31:0] i_wdata = '0, o_rdata;
  logic o_empty, o_full;
  logic [15:0] o_queued;
  int n_vec = 0, n_bad = 0;
  logic [31:0] mq[$];
  logic [31:0] m_rdata;
  typedef struct {
    logic w;
    logic [31:0] d;
    logic r;
    logic [31:0] rd;
    logic e;
    logic f;
    logic [15:0] q;
  } vec_t;
  vec_t tbl[10];
  sync_fifo dut (
    .i_clock(i_clock), .i_reset(i_reset), .i_write(i_write), .i_wdata(i_wdata),
    .i_read(i_read), .o_rdata(o_rdata), .o_empty(o_empty), .o_full(o_full), .o_queued(o_queued)
  );
  always #5 i_clock = ~i_clock;
  task automatic step(input logic rst, input logic w, input logic [31:0] d, input logic r);
    @(negedge i_clock);
    i_reset = rst;
    i_write = w;
    i_wdata = d;
    i_read = r;
    @(posedge i_clock);
    #1;
    i_reset = 1;
    i_write = 0;
    i_read = 0;
  endtask
  task automatic check(input string name, input logic [31:0] rd, input logic e, input logic f, input logic [15:0] q);
    n_vec++;
    if (o_rdata !== rd || o_empty !== e || o_full !== f || o_queued !== q) begin
      n_bad++;
      $display("FAIL %s: got rdata=%h empty=%b full=%b queued=%0d, want rdata=%h empty=%b full=%b queued=%0d",
               name, o_rdata, o_empty, o_full, o_queued, rd, e, f, q);
    end
  endtask
  task automatic mstep(input string name, input logic w, input logic [31:0] d, input logic r);
    bit do_pop, do_push;
    do_pop = r && mq.size() != 0;
    do_push = w && mq.size() != 32;
    step(1, w, d, r);
    if (do_pop) m_rdata = mq.pop_front();
    if (do_push) mq.push_back(d);
    check(name, m_rdata, mq.size() == 0, mq.size() == 32, 16'(mq.size()));
  endtask
  initial begin
    tbl[0] = '{1'b1, 32'hA1, 1'b0, 32'h0,  1'b0, 1'b0, 16'd1};
    tbl[1] = '{1'b1, 32'hA2, 1'b0, 32'h0,  1'b0, 1'b0, 16'd2};
    tbl[2] = '{1'b1, 32'hA3, 1'b0, 32'h0,  1'b0, 1'b0, 16'd3};
    tbl[3] = '{1'b0, 32'h0,  1'b1, 32'hA1, 1'b0, 1'b0, 16'd2};
    tbl[4] = '{1'b0, 32'h0,  1'b1, 32'hA2, 1'b0, 1'b0, 16'd1};
    tbl[5] = '{1'b0, 32'h0,  1'b1, 32'hA3, 1'b1, 1'b0, 16'd0};
    tbl[6] = '{1'b0, 32'h0,  1'b1, 32'hA3, 1'b1, 1'b0, 16'd0};
    tbl[7] = '{1'b1, 32'h55, 1'b1, 32'hA3, 1'b0, 1'b0, 16'd1};
    tbl[8] = '{1'b0, 32'h0,  1'b1, 32'h55, 1'b1, 1'b0, 16'd0};
    tbl[9] = '{1'b0, 32'h0,  1'b0, 32'h55, 1'b1, 1'b0, 16'd0};
    step(0, 1, 32'hBEEF, 1);
    step(0, 1, 32'hBEEF, 1);
    check("reset", 32'h0, 1'b1, 1'b0, 16'd0);
    for (int i = 0; i < 10; i++) begin
      step(1, tbl[i].w, tbl[i].d, tbl[i].r);
      check($sformatf("tbl%0d", i), tbl[i].rd, tbl[i].e, tbl[i].f, tbl[i].q);
    end
    m_rdata = 32'h55;
    for (int i = 0; i < 32; i++) mstep("fill", 1, 32'h100 + i, 0);
    check("full32", 32'h55, 1'b0, 1'b1, 16'd32);
    mstep("push_full", 1, 32'hDEAD, 0);
    for (int i = 0; i < 32; i++) begin
      mstep("drain", 0, 0, 1);
      if (o_rdata === 32'hDEAD) begin
        n_vec++;
        n_bad++;
        $display("FAIL drain_dead: got rdata=%h, dropped value must never appear", o_rdata);
      end
    end
    check("drained", 32'h11F, 1'b1, 1'b0, 16'd0);
    for (int i = 0; i < 5; i++) mstep("pre5", 1, 32'h200 + i, 0);
    for (int i = 0; i < 40; i++) mstep("wrap", 1, 32'h300 + i, 1);
    check("wrap_end", 32'h300 + 34, 1'b0, 1'b0, 16'd5);
    for (int i = 0; i < 5; i++) mstep("fill10", 1, 32'h400 + i, 0);
    check("q10", 32'h322, 1'b0, 1'b0, 16'd10);
    step(0, 1, 32'hBAD, 1);
    mq.delete();
    m_rdata = 32'h0;
    check("midreset", 32'h0, 1'b1, 1'b0, 16'd0);
    mstep("post_push", 1, 32'h77, 0);
    mstep("post_pop", 0, 0, 1);
    check("post_data", 32'h77, 1'b1, 1'b0, 16'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
